// File: rtl/facto_host_master.sv
// Bus initiator that runs one FactoCore factorial job per accepted start:
// load operand, arm interrupt, start, wait (interrupt or OPDONE poll), read result, clear.
module facto_host_master #(
    parameter logic [15:0] BASE_ADDR   = 16'h7000,
    parameter bit          USE_INTR    = 1'b1,
    parameter int unsigned POLL_GAP    = 8,
    parameter int unsigned TIMEOUT_CYC = 65535
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         start,
    input  logic [63:0]  operand,
    output logic         busy,
    output logic         done,
    output logic         error,
    output logic [127:0] result,
    output logic         m_sel,
    output logic         m_wr,
    output logic [15:0]  m_addr,
    output logic [63:0]  m_dout,
    input  logic [63:0]  m_din,
    input  logic         interrupt
);

    localparam logic [15:0] OFS_OPSTART  = 16'h0000;
    localparam logic [15:0] OFS_OPCLEAR  = 16'h0008;
    localparam logic [15:0] OFS_OPDONE   = 16'h0010;
    localparam logic [15:0] OFS_INTR_EN  = 16'h0018;
    localparam logic [15:0] OFS_OPERAND  = 16'h0020;
    localparam logic [15:0] OFS_RESULT_H = 16'h0028;
    localparam logic [15:0] OFS_RESULT_L = 16'h0030;

    typedef enum logic [3:0] {
        S_IDLE, S_W_OPND, S_W_IEN, S_W_START, S_WAIT,
        S_POLL, S_R_HI, S_R_LO, S_W_CLR, S_FIN
    } state_t;

    state_t      state_r;
    logic [31:0] wait_cnt_r;
    logic [15:0] gap_cnt_r;
    logic        timeout_s;
    logic        gap_end_s;

    // The wait counter value is the number of WAIT/POLL cycles already completed.
    assign timeout_s = (TIMEOUT_CYC != 32'd0) && (wait_cnt_r == 32'(TIMEOUT_CYC - 32'd1));
    assign gap_end_s = (gap_cnt_r == 16'(POLL_GAP - 32'd1));

    // Job sequencer; bus outputs are registered so each access occupies the state's own cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= S_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
            result     <= 128'd0;
            m_sel      <= 1'b0;
            m_wr       <= 1'b0;
            m_addr     <= 16'd0;
            m_dout     <= 64'd0;
            wait_cnt_r <= 32'd0;
            gap_cnt_r  <= 16'd0;
        end else begin
            done <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (start) begin
                        busy    <= 1'b1;
                        error   <= 1'b0;
                        result  <= 128'd0;
                        m_sel   <= 1'b1;
                        m_wr    <= 1'b1;
                        m_addr  <= BASE_ADDR + OFS_OPERAND;
                        m_dout  <= operand;
                        state_r <= S_W_OPND;
                    end
                end
                S_W_OPND: begin
                    m_addr  <= BASE_ADDR + OFS_INTR_EN;
                    m_dout  <= {63'd0, USE_INTR};
                    state_r <= S_W_IEN;
                end
                S_W_IEN: begin
                    m_addr  <= BASE_ADDR + OFS_OPSTART;
                    m_dout  <= 64'd1;
                    state_r <= S_W_START;
                end
                S_W_START: begin
                    m_sel      <= 1'b0;
                    m_wr       <= 1'b0;
                    wait_cnt_r <= 32'd0;
                    gap_cnt_r  <= 16'd0;
                    state_r    <= S_WAIT;
                end
                S_WAIT: begin
                    wait_cnt_r <= wait_cnt_r + 32'd1;
                    gap_cnt_r  <= gap_cnt_r + 16'd1;
                    if (USE_INTR && interrupt) begin
                        m_sel   <= 1'b1;
                        m_addr  <= BASE_ADDR + OFS_RESULT_H;
                        state_r <= S_R_HI;
                    end else if (timeout_s) begin
                        error   <= 1'b1;
                        result  <= 128'd0;
                        m_sel   <= 1'b1;
                        m_wr    <= 1'b1;
                        m_addr  <= BASE_ADDR + OFS_OPCLEAR;
                        m_dout  <= 64'd1;
                        state_r <= S_W_CLR;
                    end else if (!USE_INTR && gap_end_s) begin
                        m_sel   <= 1'b1;
                        m_addr  <= BASE_ADDR + OFS_OPDONE;
                        state_r <= S_POLL;
                    end
                end
                S_POLL: begin
                    wait_cnt_r <= wait_cnt_r + 32'd1;
                    gap_cnt_r  <= 16'd0;
                    if (m_din[0]) begin
                        m_addr  <= BASE_ADDR + OFS_RESULT_H;
                        state_r <= S_R_HI;
                    end else if (timeout_s) begin
                        error   <= 1'b1;
                        result  <= 128'd0;
                        m_wr    <= 1'b1;
                        m_addr  <= BASE_ADDR + OFS_OPCLEAR;
                        m_dout  <= 64'd1;
                        state_r <= S_W_CLR;
                    end else begin
                        m_sel   <= 1'b0;
                        state_r <= S_WAIT;
                    end
                end
                S_R_HI: begin
                    result[127:64] <= m_din;
                    m_addr         <= BASE_ADDR + OFS_RESULT_L;
                    state_r        <= S_R_LO;
                end
                S_R_LO: begin
                    result[63:0] <= m_din;
                    m_wr         <= 1'b1;
                    m_addr       <= BASE_ADDR + OFS_OPCLEAR;
                    m_dout       <= 64'd1;
                    state_r      <= S_W_CLR;
                end
                S_W_CLR: begin
                    m_sel   <= 1'b0;
                    m_wr    <= 1'b0;
                    state_r <= S_FIN;
                end
                S_FIN: begin
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    m_sel   <= 1'b0;
                    m_wr    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

endmodule
